// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, NOP encoding and default widths.
package mips_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a lw sitting in ID/EX.
module hazard_detect
    import mips_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             valid_id,
    input  logic [5:0]       op,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    output logic             lu
);
    logic reads_rs;
    logic reads_rt;

    always_comb begin
        reads_rs = op inside {OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_LW, OP_SW};
        reads_rt = op inside {OP_RTYPE, OP_BEQ, OP_SW};
        // $zero is never a real producer, so a lw targeting it cannot cause a stall
        lu = valid_id & id_ex_mem_read & (id_ex_rt != '0) &
             ((reads_rs & (rs == id_ex_rt)) | (reads_rt & (rt == id_ex_rt)));
    end
endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, jump decode, wrong-path squash and
// saturating stall/flush counters.
module if_id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] Instruction_IF,
    input  logic [DATA_W-1:0] PC_Address_next,
    input  logic              stop,
    input  logic              PCSrc,
    input  logic              id_ex_mem_read,
    input  logic [REG_W-1:0]  id_ex_rt,
    output logic [DATA_W-1:0] Instruction_ID,
    output logic [DATA_W-1:0] PC_Plus4_ID,
    output logic              valid_ID,
    output logic              PCWrite,
    output logic              jump,
    output logic [DATA_W-1:0] j_address,
    output logic              bubble_ID,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              lu;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .valid_id       (valid_q),
        .op             (instr_q[31:26]),
        .rs             (instr_q[25:21]),
        .rt             (instr_q[20:16]),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .lu             (lu)
    );

    // A taken branch is older than the jump in ID, so it wins the redirect
    assign jump      = valid_q & (instr_q[31:26] == OP_J) & ~PCSrc;
    assign PCWrite   = ~(lu & ~PCSrc);
    assign bubble_ID = (lu | ~valid_q) & ~reset;
    assign j_address = {pc_q[DATA_W-1:DATA_W-4], instr_q[25:0], 2'b00};

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (PCSrc) begin
            instr_d = NOP;
            valid_d = 1'b0;
            flush_d = sat_inc(flush_q);
        end else if (!stop) begin
            if (lu) begin
                stall_d = sat_inc(stall_q);
            end else if (jump) begin
                instr_d = NOP;
                valid_d = 1'b0;
                flush_d = sat_inc(flush_q);
            end else begin
                instr_d = Instruction_IF;
                pc_d    = PC_Address_next;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= NOP;
            pc_q    <= '0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign Instruction_ID = instr_q;
    assign PC_Plus4_ID    = pc_q;
    assign valid_ID       = valid_q;
    assign stall_count    = stall_q;
    assign flush_count    = flush_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Scenario tests plus a randomized run against a behavioural model of the IF/ID stage.
module tb_if_id_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] Instruction_IF, PC_Address_next;
    logic        stop, PCSrc, id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [31:0] Instruction_ID, PC_Plus4_ID, j_address;
    logic        valid_ID, PCWrite, jump, bubble_ID;
    logic [15:0] stall_count, flush_count;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ADDI = 32'h2008_0020;  // addi $8,$0,32
    localparam logic [31:0] ADD  = 32'h0109_8020;  // add $16,$8,$9
    localparam logic [31:0] JMP  = 32'h0800_0006;  // j 0x18

    if_id_stage dut (
        .clock(clock), .reset(reset), .Instruction_IF(Instruction_IF),
        .PC_Address_next(PC_Address_next), .stop(stop), .PCSrc(PCSrc),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .Instruction_ID(Instruction_ID), .PC_Plus4_ID(PC_Plus4_ID), .valid_ID(valid_ID),
        .PCWrite(PCWrite), .jump(jump), .j_address(j_address), .bubble_ID(bubble_ID),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        stop = 0; PCSrc = 0; id_ex_mem_read = 0; id_ex_rt = 0;
        Instruction_IF = 32'h0; PC_Address_next = 32'h0;
    endtask

    task automatic test_reset();
        clear_in();
        reset = 1;
        #3;
        n_cmp++; if (Instruction_ID !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", Instruction_ID); end
        n_cmp++; if (PC_Plus4_ID !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", PC_Plus4_ID); end
        n_cmp++; if (valid_ID !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_ID); end
        n_cmp++; if ({PCWrite, jump, bubble_ID} !== 3'b100) begin n_err++; $display("FAIL reset_comb got %b want 100", {PCWrite, jump, bubble_ID}); end
        n_cmp++; if ({stall_count, flush_count} !== 32'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", {stall_count, flush_count}); end
        tick();
        reset = 0;
    endtask

    task automatic test_stream();
        Instruction_IF = ADDI; PC_Address_next = 32'h4;
        tick();
        n_cmp++; if ({Instruction_ID, PC_Plus4_ID} !== {ADDI, 32'h4}) begin n_err++; $display("FAIL stream_addi got %h/%h want %h/4", Instruction_ID, PC_Plus4_ID, ADDI); end
        n_cmp++; if ({valid_ID, PCWrite} !== 2'b11) begin n_err++; $display("FAIL stream_addi_ctl got %b want 11", {valid_ID, PCWrite}); end
        Instruction_IF = ADD; PC_Address_next = 32'h8;
        tick();
        n_cmp++; if ({Instruction_ID, PC_Plus4_ID} !== {ADD, 32'h8}) begin n_err++; $display("FAIL stream_add got %h/%h want %h/8", Instruction_ID, PC_Plus4_ID, ADD); end
        n_cmp++; if ({valid_ID, PCWrite, bubble_ID} !== 3'b110) begin n_err++; $display("FAIL stream_add_ctl got %b want 110", {valid_ID, PCWrite, bubble_ID}); end
    endtask

    task automatic test_load_use();
        // ID holds add $16,$8,$9
        id_ex_mem_read = 1; id_ex_rt = 5'd9;
        Instruction_IF = ADDI; PC_Address_next = 32'hC;
        #1;
        n_cmp++; if ({PCWrite, bubble_ID} !== 2'b01) begin n_err++; $display("FAIL lu_comb got %b want 01", {PCWrite, bubble_ID}); end
        tick();
        id_ex_mem_read = 0;
        #1;
        n_cmp++; if ({Instruction_ID, valid_ID} !== {ADD, 1'b1}) begin n_err++; $display("FAIL lu_hold got %h/%b want %h/1", Instruction_ID, valid_ID, ADD); end
        n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt got %0d want 1", stall_count); end
        n_cmp++; if ({PCWrite, bubble_ID} !== 2'b10) begin n_err++; $display("FAIL lu_release got %b want 10", {PCWrite, bubble_ID}); end
        id_ex_mem_read = 1; id_ex_rt = 5'd0;
        #1;
        n_cmp++; if ({PCWrite, bubble_ID} !== 2'b10) begin n_err++; $display("FAIL lu_rt0 got %b want 10", {PCWrite, bubble_ID}); end
        tick();
        n_cmp++; if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_rt0_cnt got %0d want 1", stall_count); end
        clear_in();
    endtask

    task automatic test_jump();
        Instruction_IF = JMP; PC_Address_next = 32'h40;
        tick();
        Instruction_IF = ADDI; PC_Address_next = 32'h44;
        #1;
        n_cmp++; if ({jump, j_address} !== {1'b1, 32'h18}) begin n_err++; $display("FAIL jump_decode got %b/%h want 1/00000018", jump, j_address); end
        tick();
        n_cmp++; if ({valid_ID, Instruction_ID} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL jump_squash got %b/%h want 0/0", valid_ID, Instruction_ID); end
        n_cmp++; if (flush_count !== 16'd1) begin n_err++; $display("FAIL jump_flush_cnt got %0d want 1", flush_count); end
    endtask

    task automatic test_pcsrc_priority();
        Instruction_IF = JMP; PC_Address_next = 32'h50;
        tick();
        PCSrc = 1; id_ex_mem_read = 1; id_ex_rt = 5'd1;
        #1;
        n_cmp++; if ({jump, PCWrite} !== 2'b01) begin n_err++; $display("FAIL pcsrc_j got %b want 01", {jump, PCWrite}); end
        tick();
        n_cmp++; if ({valid_ID, flush_count} !== {1'b0, 16'd2}) begin n_err++; $display("FAIL pcsrc_j_next got %b/%0d want 0/2", valid_ID, flush_count); end
        // branch flush also beats a live load-use stall
        clear_in();
        Instruction_IF = ADD;
        tick();
        PCSrc = 1; id_ex_mem_read = 1; id_ex_rt = 5'd8;
        #1;
        n_cmp++; if ({PCWrite, bubble_ID} !== 2'b11) begin n_err++; $display("FAIL pcsrc_lu got %b want 11", {PCWrite, bubble_ID}); end
        tick();
        n_cmp++; if ({valid_ID, stall_count, flush_count} !== {1'b0, 16'd1, 16'd3}) begin n_err++; $display("FAIL pcsrc_lu_next got %b/%0d/%0d want 0/1/3", valid_ID, stall_count, flush_count); end
        clear_in();
    endtask

    task automatic test_stop();
        Instruction_IF = ADDI; PC_Address_next = 32'h60;
        tick();
        stop = 1;
        for (int i = 0; i < 3; i++) begin
            Instruction_IF = $urandom; PC_Address_next = $urandom;
            tick();
            n_cmp++; if ({Instruction_ID, PC_Plus4_ID, valid_ID, stall_count, flush_count} !== {ADDI, 32'h60, 1'b1, 16'd1, 16'd3})
                begin n_err++; $display("FAIL stop_hold cyc %0d got %h/%h/%b/%0d/%0d", i, Instruction_ID, PC_Plus4_ID, valid_ID, stall_count, flush_count); end
        end
        PCSrc = 1;
        tick();
        n_cmp++; if ({valid_ID, Instruction_ID, flush_count} !== {1'b0, 32'h0, 16'd4}) begin n_err++; $display("FAIL stop_pcsrc got %b/%h/%0d want 0/0/4", valid_ID, Instruction_ID, flush_count); end
        clear_in();
    endtask

    task automatic test_reset_mid_stall();
        Instruction_IF = ADD; PC_Address_next = 32'h70;
        tick();
        id_ex_mem_read = 1; id_ex_rt = 5'd9;
        tick();
        reset = 1;
        #1;
        n_cmp++; if ({Instruction_ID, PC_Plus4_ID, valid_ID, stall_count, flush_count} !== {64'h0, 1'b0, 32'h0})
            begin n_err++; $display("FAIL rst_async got %h/%h/%b/%0d/%0d want all 0", Instruction_ID, PC_Plus4_ID, valid_ID, stall_count, flush_count); end
        n_cmp++; if ({PCWrite, jump, bubble_ID} !== 3'b100) begin n_err++; $display("FAIL rst_async_comb got %b want 100", {PCWrite, jump, bubble_ID}); end
        clear_in();
        Instruction_IF = ADDI; PC_Address_next = 32'h4;
        #1 reset = 0;
        tick();
        n_cmp++; if ({Instruction_ID, PC_Plus4_ID, valid_ID} !== {ADDI, 32'h4, 1'b1}) begin n_err++; $display("FAIL rst_resume got %h/%h/%b", Instruction_ID, PC_Plus4_ID, valid_ID); end
    endtask

    // Behavioural model: architectural IF/ID contents and counters
    logic [31:0] m_instr, m_pc;
    logic        m_valid;
    int          m_stall, m_flush;

    function automatic bit m_lu(input logic [31:0] ins, input bit v, input bit mr, input logic [4:0] drt);
        int op = int'(ins[31:26]);
        bit uses_rs = op inside {0, 4, 8, 12, 35, 43};
        bit uses_rt = op inside {0, 4, 43};
        if (!v || !mr || drt == 0) return 0;
        return (uses_rs && ins[25:21] == drt) || (uses_rt && ins[20:16] == drt);
    endfunction

    task automatic test_random();
        int ops[8] = '{0, 2, 4, 8, 12, 35, 43, 15};
        bit lu_e, j_e;
        reset = 1; #1; reset = 0;
        clear_in();
        m_instr = 0; m_pc = 0; m_valid = 0; m_stall = 0; m_flush = 0;
        for (int c = 0; c < 400; c++) begin
            Instruction_IF = {ops[$urandom_range(0, 7)][5:0], 5'($urandom_range(0, 3)),
                              5'($urandom_range(0, 3)), 16'($urandom)};
            PC_Address_next = $urandom;
            stop = ($urandom_range(0, 9) == 0);
            PCSrc = ($urandom_range(0, 9) == 0);
            id_ex_mem_read = ($urandom_range(0, 9) < 4);
            id_ex_rt = 5'($urandom_range(0, 3));
            #1;
            lu_e = m_lu(m_instr, m_valid, id_ex_mem_read, id_ex_rt);
            j_e = m_valid && m_instr[31:26] == 6'd2 && !PCSrc;
            n_cmp++; if ({PCWrite, jump, bubble_ID} !== {!(lu_e && !PCSrc), j_e, lu_e || !m_valid})
                begin n_err++; $display("FAIL rnd_comb cyc %0d got %b want %b", c, {PCWrite, jump, bubble_ID}, {!(lu_e && !PCSrc), j_e, lu_e || !m_valid}); end
            if (j_e) begin
                n_cmp++; if (j_address !== {m_pc[31:28], m_instr[25:0], 2'b00}) begin n_err++; $display("FAIL rnd_jaddr cyc %0d got %h", c, j_address); end
            end
            if (PCSrc) begin m_instr = 0; m_valid = 0; m_flush++; end
            else if (!stop) begin
                if (lu_e) m_stall++;
                else if (j_e) begin m_instr = 0; m_valid = 0; m_flush++; end
                else begin m_instr = Instruction_IF; m_pc = PC_Address_next; m_valid = 1; end
            end
            tick();
            n_cmp++; if ({Instruction_ID, valid_ID, stall_count, flush_count} !== {m_instr, m_valid, 16'(m_stall), 16'(m_flush)})
                begin n_err++; $display("FAIL rnd_state cyc %0d got %h/%b/%0d/%0d want %h/%b/%0d/%0d", c, Instruction_ID, valid_ID, stall_count, flush_count, m_instr, m_valid, m_stall, m_flush); end
            if (m_valid) begin
                n_cmp++; if (PC_Plus4_ID !== m_pc) begin n_err++; $display("FAIL rnd_pc cyc %0d got %h want %h", c, PC_Plus4_ID, m_pc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_jump();
        test_pcsrc_priority();
        test_stop();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
